// File: rtl/adder_arbiter.sv
// Round-robin arbiter feeding one shared DATA_W-bit adder, with a single-entry response holding register.
// Define ADDER_ARB_SAT_EN to saturate resp_sum on signed overflow; the default build returns the wrapped sum.
//
//   state | meaning
//   IDLE  | waiting for a request; grants one requester and captures its operands
//   ADD   | shared adder evaluates the captured operands; results are registered
//   HOLD  | response presented until the consumer takes it
module adder_arbiter #(
    parameter int DATA_W = 32,
    parameter int N_REQ  = 4,
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*DATA_W-1:0]   req_a,
    input  logic [N_REQ*DATA_W-1:0]   req_b,
    input  logic [N_REQ-1:0]          req_cin,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [ID_W-1:0]           resp_id,
    output logic [DATA_W-1:0]         resp_sum,
    output logic                      resp_cout,
    output logic                      resp_of
);

    typedef enum logic [1:0] {IDLE, ADD, HOLD} state_t;

    state_t state, state_nxt;

    logic [ID_W-1:0]   ptr;
    logic              grant_any;
    logic [ID_W-1:0]   grant_idx;
    logic              accept;

    logic [DATA_W-1:0] sel_a, sel_b;
    logic              sel_cin;

    logic [DATA_W-1:0] op_a, op_b;
    logic              op_cin;
    logic [ID_W-1:0]   op_id;

    logic [DATA_W:0]   full;
    logic [DATA_W-1:0] sum_raw, sum_out;
    logic              cout_raw, of_raw;

    // Round-robin search starting at ptr, wrapping modulo N_REQ.
    always_comb begin
        int idx;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = ID_W'(idx);
            end
        end
    end

    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_cin = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (ID_W'(k) == grant_idx) begin
                sel_a   = req_a[k*DATA_W +: DATA_W];
                sel_b   = req_b[k*DATA_W +: DATA_W];
                sel_cin = req_cin[k];
            end
        end
    end

    assign accept = (state == IDLE) && grant_any;

    // The single shared adder.
    assign full     = {1'b0, op_a} + {1'b0, op_b} + {{DATA_W{1'b0}}, op_cin};
    assign sum_raw  = full[DATA_W-1:0];
    assign cout_raw = full[DATA_W];
    assign of_raw   = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (sum_raw[DATA_W-1] != op_a[DATA_W-1]);

`ifdef ADDER_ARB_SAT_EN
    always_comb begin
        sum_out = sum_raw;
        if (of_raw) begin
            sum_out = op_a[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                     : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end
`else
    assign sum_out = sum_raw;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_any) state_nxt = ADD;
            ADD:     state_nxt = HOLD;
            HOLD:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant strobe is combinational so the requester sees it in the capture cycle.
    always_comb begin
        req_ready = '0;
        if (!rst && accept) req_ready[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_cin     <= 1'b0;
            op_id      <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_sum   <= '0;
            resp_cout  <= 1'b0;
            resp_of    <= 1'b0;
        end else begin
            if (accept) begin
                op_a   <= sel_a;
                op_b   <= sel_b;
                op_cin <= sel_cin;
                op_id  <= grant_idx;
                ptr    <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (state == ADD) begin
                resp_valid <= 1'b1;
                resp_id    <= op_id;
                resp_sum   <= sum_out;
                resp_cout  <= cout_raw;
                resp_of    <= of_raw;
            end
            if (state == HOLD && resp_ready) resp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: transaction-timeline reference model checked every cycle,
// plus directed literal cases for overflow corners, round-robin order, HOLD stability and reset in HOLD.
module tb_adder_arbiter;
    localparam int DW = 32;
    localparam int NR = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid, req_ready, req_cin;
    logic [NR*DW-1:0]  req_a, req_b;
    logic              resp_valid, resp_ready;
    logic [1:0]        resp_id;
    logic [DW-1:0]     resp_sum;
    logic              resp_cout, resp_of;

    logic [DW-1:0]     a_in [NR];
    logic [DW-1:0]     b_in [NR];

    always #5 clk = ~clk;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < NR; i++) begin
            req_a[i*DW +: DW] = a_in[i];
            req_b[i*DW +: DW] = b_in[i];
        end
    end

    adder_arbiter #(.DATA_W(DW), .N_REQ(NR)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_sum(resp_sum),
        .resp_cout(resp_cout), .resp_of(resp_of)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: timeline of accept -> valid two cycles later -> drop after handshake.
    bit          m_ok = 1'b0;
    bit          m_busy, m_rv;
    int          m_ptr, m_due, m_cyc = 0;
    logic [31:0] m_sum, p_sum;
    bit          m_cout, m_of, p_cout, p_of;
    int          m_id, p_id;
    int          g_id[$];
    int          g_cyc[$];

    function automatic int pick(input logic [NR-1:0] v, input int p);
        for (int k = 0; k < NR; k++) begin
            if (v[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    task automatic model_add(input int id, output logic [31:0] s, output bit co, output bit ov);
        logic [63:0]  u;
        longint       t;
        u  = {32'b0, a_in[id]} + {32'b0, b_in[id]} + {63'b0, req_cin[id]};
        t  = longint'($signed(a_in[id])) + longint'($signed(b_in[id])) + longint'(req_cin[id]);
        s  = u[31:0];
        co = u[32];
        ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
`ifdef ADDER_ARB_SAT_EN
        if (ov) s = (t > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
    endtask

    task automatic tick();
        logic [NR-1:0] exp_rdy;
        int pk;
        #1;
        pk = pick(req_valid, m_ptr);
        exp_rdy = '0;
        if (!m_busy && pk >= 0) exp_rdy[pk] = 1'b1;
        if (rst) begin
            chk("ready_in_reset", req_ready, 0);
        end else if (m_ok) begin
            chk("req_ready", req_ready, exp_rdy);
            chk("resp_valid", resp_valid, m_rv);
            if (m_rv) begin
                chk("resp_id", resp_id, m_id);
                chk("resp_sum", resp_sum, m_sum);
                chk("resp_cout", resp_cout, m_cout);
                chk("resp_of", resp_of, m_of);
            end
        end
        for (int i = 0; i < NR; i++) begin
            if (req_ready[i]) begin
                g_id.push_back(i);
                g_cyc.push_back(m_cyc);
            end
        end
        @(posedge clk);
        if (rst) begin
            m_ok = 1'b1; m_ptr = 0; m_busy = 1'b0; m_rv = 1'b0;
            m_sum = '0; m_cout = 1'b0; m_of = 1'b0; m_id = 0;
        end else if (m_ok) begin
            if (!m_busy) begin
                if (pk >= 0) begin
                    model_add(pk, p_sum, p_cout, p_of);
                    p_id   = pk;
                    m_busy = 1'b1;
                    m_due  = m_cyc + 2;
                    m_ptr  = (pk + 1) % NR;
                end
            end else if (m_rv) begin
                if (resp_ready) begin
                    m_rv   = 1'b0;
                    m_busy = 1'b0;
                end
            end else if (m_cyc + 1 == m_due) begin
                m_rv = 1'b1; m_sum = p_sum; m_cout = p_cout; m_of = p_of; m_id = p_id;
            end
        end
        m_cyc++;
        @(negedge clk);
    endtask

    task automatic directed(input int id, input logic [31:0] a, input logic [31:0] b, input bit cin,
                            input logic [31:0] esum, input bit eco, input bit eof);
        logic [NR-1:0] one;
        one = '0;
        one[id] = 1'b1;
        a_in[id] = a; b_in[id] = b; req_cin[id] = cin;
        req_valid = one;
        resp_ready = 1'b1;
        #1 chk("dir_ready", req_ready, one);
        tick();
        req_valid = '0;
        tick();
        #1;
        chk("dir_valid", resp_valid, 1);
        chk("dir_sum", resp_sum, esum);
        chk("dir_cout", resp_cout, eco);
        chk("dir_of", resp_of, eof);
        chk("dir_id", resp_id, id);
        tick();
        #1 chk("dir_valid_clear", resp_valid, 0);
    endtask

    initial begin
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        rst = 1'b1; req_valid = '0; req_cin = '0; resp_ready = 1'b0;
        for (int i = 0; i < NR; i++) begin a_in[i] = '0; b_in[i] = '0; end
        @(negedge clk);
        tick();
        tick();
        #1;
        chk("rst_valid", resp_valid, 0);
        chk("rst_sum", resp_sum, 0);
        chk("rst_id", resp_id, 0);
        chk("rst_cout", resp_cout, 0);
        chk("rst_of", resp_of, 0);
        rst = 1'b0;

`ifdef ADDER_ARB_SAT_EN
        directed(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
        directed(1, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b1, 1'b1);
`else
        directed(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        directed(1, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
`endif
        directed(2, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF - 32'd1, 1'b1, 1'b0);
        directed(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);

        // All requesters pending with an eager consumer: fair rotation, one accept per 3 cycles.
        for (int i = 0; i < NR; i++) begin
            a_in[i] = 32'h10 * (i + 1); b_in[i] = 32'h20; req_cin[i] = 1'b1;
        end
        req_valid = '1; resp_ready = 1'b1;
        g_id.delete(); g_cyc.delete();
        repeat (13) tick();
        chk("rr_count", g_id.size(), 5);
        for (int k = 0; k < 5 && k < g_id.size(); k++) begin
            chk("rr_order", g_id[k], exp_order[k]);
            if (k > 0) chk("rr_spacing", g_cyc[k] - g_cyc[k-1], 3);
        end

        // Stall the consumer, then reset while holding.
        resp_ready = 1'b0;
        tick();
        repeat (5) begin
            #1;
            chk("hold_valid", resp_valid, 1);
            chk("hold_sum", resp_sum, 32'h31);
            chk("hold_id", resp_id, 0);
            chk("hold_ready", req_ready, 0);
            tick();
        end
        rst = 1'b1;
        #1 chk("hold_rst_ready", req_ready, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_valid", resp_valid, 0);
        chk("post_rst_grant", req_ready, 4'b0001);
        tick();

        repeat (3000) begin
            req_valid = NR'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) req_valid = '0;
            for (int i = 0; i < NR; i++) begin
                case ($urandom_range(0, 5))
                    0: a_in[i] = 32'h7FFF_FFFF;
                    1: a_in[i] = 32'h8000_0000;
                    2: a_in[i] = 32'hFFFF_FFFF;
                    default: a_in[i] = $urandom;
                endcase
                case ($urandom_range(0, 5))
                    0: b_in[i] = 32'h0000_0001;
                    1: b_in[i] = 32'h8000_0000;
                    2: b_in[i] = 32'hFFFF_FFFF;
                    default: b_in[i] = $urandom;
                endcase
                req_cin[i] = 1'($urandom_range(0, 1));
            end
            resp_ready = ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, operand and sum width in bits.
REQ-002 Parameter N_REQ, default 4, number of requesters; SHALL be 2..8.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  N_REQ  per-requester operation request.
REQ-006 req_ready  output  N_REQ  one-hot accept strobe; bit i high means requester i's operands are captured this cycle.
REQ-007 req_a  input  N_REQ*DATA_W  flattened operand A; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-008 req_b  input  N_REQ*DATA_W  flattened operand B, same packing as req_a.
REQ-009 req_cin  input  N_REQ  per-requester carry-in.
REQ-010 resp_valid  output  1  result available.
REQ-011 resp_ready  input  1  consumer accepts the result.
REQ-012 resp_id  output  clog2(N_REQ)  index of the requester that owns the result.
REQ-013 resp_sum  output  DATA_W  two's-complement sum.
REQ-014 resp_cout  output  1  carry out of the MSB.
REQ-015 resp_of  output  1  signed overflow flag.

Function
REQ-016 The block SHALL contain exactly one DATA_W-bit adder, shared by all requesters.
REQ-017 The FSM SHALL have three states: IDLE, ADD and HOLD.
REQ-018 IDLE: if any req_valid is high, grant the requester selected by the round-robin rule, assert its req_ready combinationally in the same cycle, capture its a/b/cin/id, and go to ADD; otherwise stay in IDLE.
REQ-019 req_ready SHALL be all-zero in the ADD and HOLD states.
REQ-020 Round-robin rule: search starts at pointer p and wraps modulo N_REQ; on a grant to requester i, p becomes (i+1) mod N_REQ.
REQ-021 ADD: compute {cout,sum} = a + b + cin, register the result outputs, set resp_valid=1, and go to HOLD.
REQ-022 Overflow SHALL be of = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]), evaluated on the raw sum.
REQ-023 HOLD: hold resp_* stable while resp_ready=0; when resp_ready=1, clear resp_valid in the next cycle and go to IDLE.
REQ-024 Latency: an accept at cycle N SHALL give resp_valid=1 at cycle N+2.
REQ-025 Minimum spacing between two accepts is 3 cycles.
REQ-026 A requester that deasserts req_valid before it is granted loses nothing and is not served.
REQ-027 Requests that go unserved while the block is busy SHALL remain pending and be arbitrated on the next IDLE cycle.

Reset
REQ-028 While rst=1 at a clock edge: state=IDLE, p=0, resp_valid=0, resp_id=0, resp_sum=0, resp_cout=0, resp_of=0, captured operands=0.
REQ-029 req_ready SHALL be 0 during any cycle in which rst=1.
REQ-030 A reset asserted in ADD or HOLD SHALL discard the in-flight operation, with no response delivered afterwards.

Configuration
REQ-031 The macro ADDER_ARB_SAT_EN SHALL select saturating result behaviour.
REQ-032 With ADDER_ARB_SAT_EN defined, on overflow resp_sum saturates:
- positive overflow gives 0x7FFFFFFF;
- negative overflow gives 0x80000000 (DATA_W=32);
- resp_of and resp_cout still reflect the raw addition.
REQ-033 Without ADDER_ARB_SAT_EN, resp_sum is the raw wrapped sum.

Verification
REQ-034 Requester 0 sends a=0x7FFFFFFF, b=0x00000001, cin=0 -> response 2 cycles after accept: sum=0x80000000 (0x7FFFFFFF with SAT_EN), cout=0, of=1, id=0.
REQ-035 Requester 1 sends a=0xFFFFFFFF, b=0x80000000 -> sum=0x7FFFFFFF (0x80000000 with SAT_EN), cout=1, of=1, id=1.
REQ-036 Requester 2 sends a=0x7FFFFFFF, b=0xFFFFFFFF -> sum=0x7FFFFFFE, cout=1, of=0.
REQ-037 Requester 3 sends a=b=0xFFFFFFFF, cin=1 -> sum=0xFFFFFFFF, cout=1, of=0.
REQ-038 All four req_valid held high with resp_ready=1 -> grants in order 0,1,2,3,0, each accept 3 cycles apart.
REQ-039 resp_ready held 0 for 5 cycles -> resp_* stable and no req_ready asserted; then rst pulsed in HOLD -> resp_valid=0 next cycle and next grant goes to requester 0.
